control_unit: RTL and testbench

//  Hardwired control sequencer driving the single-bus DataPath; it replaces the hand-written per-cycle stimulus used in bring-up.

---
 rtl/cpu_ctrl_pkg.sv | 130 +++++++++++++
 rtl/ctrl_step_decode.sv | 119 +++++++++++
 rtl/control_unit.sv | 112 +++++++++++
 tb/tb_control_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: instruction and ALU
// opcodes, the step encoding, the control vector and opcode classification helpers.
package cpu_ctrl_pkg;

  localparam int unsigned OP_W = 5;

  // Instruction opcodes, IR[31:27]
  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10101;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  // ALU operation codes driven on the opcode output
  localparam logic [OP_W-1:0] ALU_NONE = 5'b00000;
  localparam logic [OP_W-1:0] ALU_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] ALU_AND  = 5'b00101;
  localparam logic [OP_W-1:0] ALU_OR   = 5'b00110;

  typedef enum logic [3:0] {
    StReset,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StT7,
    StHalt
  } step_e;

  // Where the sequencer goes after T2
  typedef enum logic [1:0] {
    ExitExec,
    ExitFetch,
    ExitHalt
  } exit_e;

  typedef struct packed {
    logic            pc_out;
    logic            mar_in;
    logic            inc_pc;
    logic            z_in;
    logic            zlow_out;
    logic            zhigh_out;
    logic            pc_in;
    logic            mdr_in;
    logic            mdr_out;
    logic            ir_in;
    logic            y_in;
    logic            gra;
    logic            grb;
    logic            grc;
    logic            r_in;
    logic            r_out;
    logic            ba_out;
    logic            c_out;
    logic            hi_in;
    logic            hi_out;
    logic            lo_in;
    logic            lo_out;
    logic            read;
    logic            write;
    logic [OP_W-1:0] alu_op;
    logic            run;
  } ctrl_t;

  function automatic logic is_ralu(logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_SHL);
  endfunction

  function automatic logic is_imm(logic [OP_W-1:0] op);
    return (op >= OP_ADDI) && (op <= OP_ORI);
  endfunction

  // ld, ldi and st all form an effective address in T3/T4
  function automatic logic is_addr(logic [OP_W-1:0] op);
    return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
  endfunction

  function automatic logic is_muldiv(logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_MUL);
  endfunction

  function automatic logic [OP_W-1:0] alu_imm(logic [OP_W-1:0] op);
    logic [OP_W-1:0] res;
    res = ALU_ADD;
    if (op == OP_ANDI) res = ALU_AND;
    else if (op == OP_ORI) res = ALU_OR;
    return res;
  endfunction

  // Final step of an instruction; StT2 means no execute steps at all
  function automatic step_e last_step(logic [OP_W-1:0] op);
    step_e res;
    res = StT2;
    if (is_ralu(op) || is_imm(op) || (op == OP_LDI)) res = StT5;
    else if ((op == OP_LD) || (op == OP_ST)) res = StT7;
    else if (is_muldiv(op)) res = StT6;
    else if ((op == OP_MFHI) || (op == OP_MFLO) || (op == OP_JR)) res = StT3;
    return res;
  endfunction

  function automatic exit_e fetch_exit(logic [OP_W-1:0] op);
    exit_e res;
    res = ExitExec;
    if (op == OP_HALT) res = ExitHalt;
    else if (last_step(op) == StT2) res = ExitFetch;
    return res;
  endfunction

endpackage

// File: rtl/ctrl_step_decode.sv
// Combinational decode of (step, instruction opcode) into the full control vector.
module ctrl_step_decode
  import cpu_ctrl_pkg::*;
(
  input  step_e           step,
  input  logic [OP_W-1:0] op,
  output ctrl_t           ctrl
);

  // Per-step strobe decode; everything defaults low so unused steps are inert
  always_comb begin
    ctrl     = '0;
    ctrl.run = (step != StReset) && (step != StHalt);
    unique case (step)
      StT0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in   = 1'b1;
      end
      StT1: begin
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
      end
      StT2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      StT3: begin
        if (is_ralu(op) || is_imm(op)) begin
          ctrl.grb   = 1'b1;
          ctrl.r_out = 1'b1;
          ctrl.y_in  = 1'b1;
        end else if (is_addr(op)) begin
          ctrl.grb    = 1'b1;
          ctrl.ba_out = 1'b1;
          ctrl.y_in   = 1'b1;
        end else if (is_muldiv(op)) begin
          ctrl.gra   = 1'b1;
          ctrl.r_out = 1'b1;
          ctrl.y_in  = 1'b1;
        end else if (op == OP_MFHI) begin
          ctrl.hi_out = 1'b1;
          ctrl.gra    = 1'b1;
          ctrl.r_in   = 1'b1;
        end else if (op == OP_MFLO) begin
          ctrl.lo_out = 1'b1;
          ctrl.gra    = 1'b1;
          ctrl.r_in   = 1'b1;
        end else if (op == OP_JR) begin
          ctrl.gra   = 1'b1;
          ctrl.r_out = 1'b1;
          ctrl.pc_in = 1'b1;
        end
      end
      StT4: begin
        if (is_ralu(op)) begin
          ctrl.grc    = 1'b1;
          ctrl.r_out  = 1'b1;
          ctrl.z_in   = 1'b1;
          ctrl.alu_op = op;
        end else if (is_imm(op)) begin
          ctrl.c_out  = 1'b1;
          ctrl.z_in   = 1'b1;
          ctrl.alu_op = alu_imm(op);
        end else if (is_addr(op)) begin
          ctrl.c_out  = 1'b1;
          ctrl.z_in   = 1'b1;
          ctrl.alu_op = ALU_ADD;
        end else if (is_muldiv(op)) begin
          ctrl.grb    = 1'b1;
          ctrl.r_out  = 1'b1;
          ctrl.z_in   = 1'b1;
          ctrl.alu_op = op;
        end
      end
      StT5: begin
        if (is_ralu(op) || is_imm(op) || (op == OP_LDI)) begin
          ctrl.zlow_out = 1'b1;
          ctrl.gra      = 1'b1;
          ctrl.r_in     = 1'b1;
        end else if ((op == OP_LD) || (op == OP_ST)) begin
          ctrl.zlow_out = 1'b1;
          ctrl.mar_in   = 1'b1;
        end else if (is_muldiv(op)) begin
          ctrl.zlow_out = 1'b1;
          ctrl.lo_in    = 1'b1;
        end
      end
      StT6: begin
        if (op == OP_LD) begin
          ctrl.read   = 1'b1;
          ctrl.mdr_in = 1'b1;
        end else if (op == OP_ST) begin
          ctrl.gra    = 1'b1;
          ctrl.r_out  = 1'b1;
          ctrl.mdr_in = 1'b1;
        end else if (is_muldiv(op)) begin
          ctrl.zhigh_out = 1'b1;
          ctrl.hi_in     = 1'b1;
        end
      end
      StT7: begin
        if (op == OP_LD) begin
          ctrl.mdr_out = 1'b1;
          ctrl.gra     = 1'b1;
          ctrl.r_in    = 1'b1;
        end else if (op == OP_ST) begin
          // MDR already holds the store data, so nothing drives the bus here
          ctrl.write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer for the single-bus DataPath: step register and
// next-step logic; strobes are a pure decode of the current step and IR opcode.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 5,
  parameter int unsigned IRW = 32
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [IRW-1:0] ir,
  output logic           PCout,
  output logic           MARin,
  output logic           IncPC,
  output logic           Zin,
  output logic           Zlowout,
  output logic           Zhighout,
  output logic           PCin,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           Yin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic           Cout,
  output logic           HIin,
  output logic           HIout,
  output logic           LOin,
  output logic           LOout,
  output logic           Read,
  output logic           Write,
  output logic [OPW-1:0] opcode,
  output logic           run
);

  logic [OPW-1:0] op;
  logic           unused_ir;
  step_e          step_q;
  exit_e          exit_q;
  ctrl_t          ctrl;

  assign op        = ir[IRW-1 -: OPW];
  assign unused_ir = ^ir[IRW-OPW-1:0];

  // Step sequencing; the T2 exit uses a flag registered from the opcode seen
  // during fetch, later steps compare against ir directly since it is stable
  always_ff @(posedge clock) begin
    if (clear) begin
      step_q <= StReset;
      exit_q <= ExitExec;
    end else begin
      exit_q <= fetch_exit(op);
      unique case (step_q)
        StReset: step_q <= StT0;
        StT0:    step_q <= StT1;
        StT1:    step_q <= StT2;
        StT2: begin
          unique case (exit_q)
            ExitHalt:  step_q <= StHalt;
            ExitFetch: step_q <= StT0;
            default:   step_q <= StT3;
          endcase
        end
        StT3, StT4, StT5, StT6: begin
          if (step_q == last_step(op)) step_q <= StT0;
          else step_q <= step_e'(step_q + 4'd1);
        end
        StT7:    step_q <= StT0;
        StHalt:  step_q <= StHalt;
        default: step_q <= StReset;
      endcase
    end
  end

  ctrl_step_decode u_decode (
    .step (step_q),
    .op   (op),
    .ctrl (ctrl)
  );

  assign PCout    = ctrl.pc_out;
  assign MARin    = ctrl.mar_in;
  assign IncPC    = ctrl.inc_pc;
  assign Zin      = ctrl.z_in;
  assign Zlowout  = ctrl.zlow_out;
  assign Zhighout = ctrl.zhigh_out;
  assign PCin     = ctrl.pc_in;
  assign MDRin    = ctrl.mdr_in;
  assign MDRout   = ctrl.mdr_out;
  assign IRin     = ctrl.ir_in;
  assign Yin      = ctrl.y_in;
  assign Gra      = ctrl.gra;
  assign Grb      = ctrl.grb;
  assign Grc      = ctrl.grc;
  assign Rin      = ctrl.r_in;
  assign Rout     = ctrl.r_out;
  assign BAout    = ctrl.ba_out;
  assign Cout     = ctrl.c_out;
  assign HIin     = ctrl.hi_in;
  assign HIout    = ctrl.hi_out;
  assign LOin     = ctrl.lo_in;
  assign LOout    = ctrl.lo_out;
  assign Read     = ctrl.read;
  assign Write    = ctrl.write;
  assign opcode   = ctrl.alu_op;
  assign run      = ctrl.run;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, hand-written
// halt/abort sequences, then random instruction streams against a microprogram model.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, MDRin, MDRout, IRin, Yin;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, HIin, HIout, LOin, LOout;
  logic Read, Write, run;
  logic [4:0] opcode;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .PCin(PCin), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Cout(Cout), .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
    .Read(Read), .Write(Write), .opcode(opcode), .run(run)
  );

  // Observed outputs packed as {opcode, run, Write, Read, 22 strobes}
  logic [29:0] act;
  assign act = {opcode, run, Write, Read, LOout, LOin, HIout, HIin, Cout, BAout, Rout, Rin,
                Grc, Grb, Gra, Yin, IRin, MDRout, MDRin, PCin, Zhighout, Zlowout, Zin,
                IncPC, MARin, PCout};

  localparam logic [29:0] PCO  = 30'd1 << 0;
  localparam logic [29:0] MARI = 30'd1 << 1;
  localparam logic [29:0] INC  = 30'd1 << 2;
  localparam logic [29:0] ZIN  = 30'd1 << 3;
  localparam logic [29:0] ZLO  = 30'd1 << 4;
  localparam logic [29:0] ZHI  = 30'd1 << 5;
  localparam logic [29:0] PCI  = 30'd1 << 6;
  localparam logic [29:0] MDRI = 30'd1 << 7;
  localparam logic [29:0] MDRO = 30'd1 << 8;
  localparam logic [29:0] IRI  = 30'd1 << 9;
  localparam logic [29:0] YIN  = 30'd1 << 10;
  localparam logic [29:0] GRA  = 30'd1 << 11;
  localparam logic [29:0] GRB  = 30'd1 << 12;
  localparam logic [29:0] GRC  = 30'd1 << 13;
  localparam logic [29:0] RIN  = 30'd1 << 14;
  localparam logic [29:0] ROUT = 30'd1 << 15;
  localparam logic [29:0] BAO  = 30'd1 << 16;
  localparam logic [29:0] COUT = 30'd1 << 17;
  localparam logic [29:0] HII  = 30'd1 << 18;
  localparam logic [29:0] HIO  = 30'd1 << 19;
  localparam logic [29:0] LOI  = 30'd1 << 20;
  localparam logic [29:0] LOO  = 30'd1 << 21;
  localparam logic [29:0] RD   = 30'd1 << 22;
  localparam logic [29:0] WR   = 30'd1 << 23;
  localparam logic [29:0] RUN  = 30'd1 << 24;

  localparam logic [29:0] W_T0 = PCO | MARI | INC | ZIN | RUN;
  localparam logic [29:0] W_T1 = ZLO | PCI | RD | MDRI | RUN;
  localparam logic [29:0] W_T2 = MDRO | IRI | RUN;

  localparam logic [31:0] I_ADD  = 32'h18918000;
  localparam logic [31:0] I_ST   = 32'h1190005A;
  localparam logic [31:0] I_MUL  = 32'h82280000;
  localparam logic [31:0] I_HALT = 32'hD8000000;
  localparam logic [31:0] I_MFHI = 32'hC0000000;
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_JR   = 32'hA8000000;
  localparam logic [31:0] I_ORI  = 32'h70880007;
  localparam logic [31:0] I_LD   = 32'h00880010;

  function automatic logic [29:0] opf(input logic [4:0] o);
    return {o, 25'd0};
  endfunction

  // Microprogram model: number of execute cycles after fetch for each opcode
  function automatic int exec_len(input logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd14) return 3;
    case (op)
      5'd0, 5'd2:           return 5;
      5'd1:                 return 3;
      5'd15, 5'd16:         return 4;
      5'd21, 5'd24, 5'd25:  return 1;
      default:              return 0;
    endcase
  endfunction

  // Expected control word for execute cycle k (0 = T3) of opcode op
  function automatic logic [29:0] exec_word(input logic [4:0] op, input int k);
    logic [29:0] w [5];
    logic [4:0]  immop;
    for (int j = 0; j < 5; j++) w[j] = '0;
    immop = (op == 5'd13) ? 5'd5 : (op == 5'd14) ? 5'd6 : 5'd3;
    if (op >= 5'd3 && op <= 5'd11) begin
      w[0] = GRB | ROUT | YIN;  w[1] = GRC | ROUT | ZIN | opf(op);  w[2] = ZLO | GRA | RIN;
    end else if (op >= 5'd12 && op <= 5'd14) begin
      w[0] = GRB | ROUT | YIN;  w[1] = COUT | ZIN | opf(immop);  w[2] = ZLO | GRA | RIN;
    end else begin
      case (op)
        5'd0: begin
          w[0] = GRB | BAO | YIN;  w[1] = COUT | ZIN | opf(5'd3);  w[2] = ZLO | MARI;
          w[3] = RD | MDRI;        w[4] = MDRO | GRA | RIN;
        end
        5'd1: begin
          w[0] = GRB | BAO | YIN;  w[1] = COUT | ZIN | opf(5'd3);  w[2] = ZLO | GRA | RIN;
        end
        5'd2: begin
          w[0] = GRB | BAO | YIN;  w[1] = COUT | ZIN | opf(5'd3);  w[2] = ZLO | MARI;
          w[3] = GRA | ROUT | MDRI; w[4] = WR;
        end
        5'd15, 5'd16: begin
          w[0] = GRA | ROUT | YIN;  w[1] = GRB | ROUT | ZIN | opf(op);
          w[2] = ZLO | LOI;         w[3] = ZHI | HII;
        end
        5'd24: w[0] = HIO | GRA | RIN;
        5'd25: w[0] = LOO | GRA | RIN;
        5'd21: w[0] = GRA | ROUT | PCI;
        default: ;
      endcase
    end
    return w[k] | RUN;
  endfunction

  // mode: 0 reset, 1 running at cycle pos of the instruction, 2 halted
  function automatic logic [29:0] model_word(input int mode, input int pos, input logic [4:0] op);
    if (mode != 1) return '0;
    if (pos == 0) return W_T0;
    if (pos == 1) return W_T1;
    if (pos == 2) return W_T2;
    return exec_word(op, pos - 3);
  endfunction

  task automatic check(input string nm, input logic [29:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
    total++;
    if (Read === 1'b1 && Write === 1'b1) begin
      bad++;
      $display("FAIL rd_wr_excl %s: Read=%b Write=%b want not both", nm, Read, Write);
    end
    total++;
    if ($countones({PCout, Zlowout, Zhighout, MDRout, Rout, HIout, LOout, Cout}) > 1) begin
      bad++;
      $display("FAIL bus_drivers %s: got %b want at most one", nm,
               {PCout, Zlowout, Zhighout, MDRout, Rout, HIout, LOout, Cout});
    end
  endtask

  // One cycle: drive inputs just after the falling edge, check, cross the rising edge
  task automatic cyc(input logic c, input logic [31:0] i, input logic [29:0] exp,
                     input string nm);
    clear = c;
    ir    = i;
    #1;
    check(nm, exp);
    @(posedge clock);
    @(negedge clock);
  endtask

  typedef struct {
    logic        c;
    logic [31:0] i;
    logic [29:0] e;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic [31:0] i, input logic [29:0] e);
    vecs.push_back('{c, i, e});
  endtask

  task automatic add_fetch(input logic [31:0] i);
    add(1'b0, i, W_T0);
    add(1'b0, i, W_T1);
    add(1'b0, i, W_T2);
  endtask

  int          mode;
  int          pos;
  logic [31:0] cur;
  logic [31:0] rnd;
  logic        c;

  initial begin
    // Directed table: reset, add, st, mul, ori, mfhi, nop, jr
    add(1'b1, 32'h0, '0);
    add(1'b0, I_ADD, '0);
    add_fetch(I_ADD);
    add(1'b0, I_ADD, GRB | ROUT | YIN | RUN);
    add(1'b0, I_ADD, GRC | ROUT | ZIN | opf(5'b00011) | RUN);
    add(1'b0, I_ADD, ZLO | GRA | RIN | RUN);
    add_fetch(I_ST);
    add(1'b0, I_ST, GRB | BAO | YIN | RUN);
    add(1'b0, I_ST, COUT | ZIN | opf(5'b00011) | RUN);
    add(1'b0, I_ST, ZLO | MARI | RUN);
    add(1'b0, I_ST, GRA | ROUT | MDRI | RUN);
    add(1'b0, I_ST, WR | RUN);
    add_fetch(I_MUL);
    add(1'b0, I_MUL, GRA | ROUT | YIN | RUN);
    add(1'b0, I_MUL, GRB | ROUT | ZIN | opf(5'b10000) | RUN);
    add(1'b0, I_MUL, ZLO | LOI | RUN);
    add(1'b0, I_MUL, ZHI | HII | RUN);
    add_fetch(I_ORI);
    add(1'b0, I_ORI, GRB | ROUT | YIN | RUN);
    add(1'b0, I_ORI, COUT | ZIN | opf(5'b00110) | RUN);
    add(1'b0, I_ORI, ZLO | GRA | RIN | RUN);
    add_fetch(I_MFHI);
    add(1'b0, I_MFHI, HIO | GRA | RIN | RUN);
    add_fetch(I_NOP);
    add_fetch(I_JR);
    add(1'b0, I_JR, GRA | ROUT | PCI | RUN);

    clear = 1'b1;
    ir    = '0;
    @(posedge clock);
    @(negedge clock);
    foreach (vecs[k]) cyc(vecs[k].c, vecs[k].i, vecs[k].e, $sformatf("vec%0d", k));

    // Halt: held idle for 20 cycles, then a clear pulse restarts fetch
    cyc(1'b0, I_HALT, W_T0, "halt_t0");
    cyc(1'b0, I_HALT, W_T1, "halt_t1");
    cyc(1'b0, I_HALT, W_T2, "halt_t2");
    for (int k = 0; k < 20; k++) cyc(1'b0, I_HALT, '0, $sformatf("halt_hold%0d", k));
    cyc(1'b1, I_HALT, '0, "halt_clr");
    cyc(1'b0, I_LD, '0, "halt_reset");

    // ld aborted by clear during T4, then refetched and completed
    cyc(1'b0, I_LD, W_T0, "ld_t0");
    cyc(1'b0, I_LD, W_T1, "ld_t1");
    cyc(1'b0, I_LD, W_T2, "ld_t2");
    cyc(1'b0, I_LD, GRB | BAO | YIN | RUN, "ld_t3");
    cyc(1'b1, I_LD, COUT | ZIN | opf(5'b00011) | RUN, "abort_t4");
    cyc(1'b0, I_LD, '0, "abort_reset");
    cyc(1'b0, I_LD, W_T0, "re_t0");
    cyc(1'b0, I_LD, W_T1, "re_t1");
    cyc(1'b0, I_LD, W_T2, "re_t2");
    cyc(1'b0, I_LD, GRB | BAO | YIN | RUN, "re_t3");
    cyc(1'b0, I_LD, COUT | ZIN | opf(5'b00011) | RUN, "re_t4");
    cyc(1'b0, I_LD, ZLO | MARI | RUN, "re_t5");
    cyc(1'b0, I_LD, RD | MDRI | RUN, "re_t6");
    cyc(1'b0, I_LD, MDRO | GRA | RIN | RUN, "re_t7");
    cyc(1'b0, I_LD, W_T0, "re_next_t0");

    // Random instruction stream with occasional clears, checked against the model
    clear = 1'b1;
    @(posedge clock);
    @(negedge clock);
    mode = 0;
    pos  = 0;
    cur  = '0;
    for (int n = 0; n < 3000; n++) begin
      c = ($urandom_range(0, 99) < ((mode == 2) ? 25 : 2));
      if (mode == 0 || (mode == 1 && pos == 0)) begin
        rnd = $urandom();
        cur = rnd;
      end
      cyc(c, cur, model_word(mode, pos, cur[31:27]), "rand");
      if (c) begin
        mode = 0;
        pos  = 0;
      end else if (mode == 0) begin
        mode = 1;
        pos  = 0;
      end else if (mode == 1) begin
        if (pos + 1 < 3 + exec_len(cur[31:27])) pos++;
        else if (cur[31:27] == 5'b11011) mode = 2;
        else pos = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
